mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage pipeline: it consumes the registered EXE→MEM bundle (`EXE_out_t`) and performs loads and stores on the data-memory bus through a valid/ready handshake. It produces byte strobes, aligns and sign-extends load data, and stalls upstream while the memory is busy. It registers the result into the MEM→WB bundle (`MEM_out_t`).

## Interface
Parameters:
- `ADDR_W`, 32, data-memory byte-address width.

Ports:
- `Clock`  in  1  sole clock, rising edge.
- `nReset`  in  1  asynchronous, active-low reset.
- `EXE_out`  in  `EXE_out_t`  fields used: rs2 (store data), rd, result (address or ALU value), Wmem, Rmem, Wreg, func3.
- `MEM_out`  out  `MEM_out_t`  registered fields: rd[4:0], wdata[31:0], Wreg.
- `stall`  out  1  combinational; upstream holds `EXE_out` while high.
- `dmem_req`  out  1  bus request valid.
- `dmem_we`  out  1  1 = store, 0 = load.
- `dmem_addr`  out  ADDR_W  word-aligned address, with bits [1:0] forced to 0.
- `dmem_be`  out  4  byte-lane enables.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_ready`  in  1  completes the current request. For loads, `dmem_rdata` is valid in the same cycle.
- `dmem_rdata`  in  32  load word.
- `misalign`  out  1  registered one-cycle flag for a misaligned access. Tied to 0 when the feature is compiled out.

## Operation
- A memory operation is present when `Wmem|Rmem`. If both are set, the store takes priority.
- States: IDLE, BUSY.
- IDLE, no memory operation:
  - Pass rd/result/Wreg into `MEM_out` at the next edge.
  - `dmem_req` = 0 and `stall` = 0.
- IDLE, memory operation present:
  - Drive `dmem_req` = 1 combinationally from `EXE_out`.
  - If `dmem_ready` = 1: complete this cycle and stay in IDLE.
  - If `dmem_ready` = 0: latch addr, we, be, wdata, rd, func3 and Wreg; go to BUSY; `stall` = 1.
- BUSY:
  - Drive the bus from the latched copy. The request stays stable until ready.
  - `stall` = !`dmem_ready`.
  - When `dmem_ready` = 1: complete and return to IDLE.
- While stalled, `MEM_out` receives a bubble: Wreg = 0, rd = 0, wdata = 0.
- Store strobes, using a = addr[1:0]:
  - SB (000): be = 0001<<a; wdata = {4{rs2[7:0]}}.
  - SH (001): be = 0011<<{a[1],1'b0}; wdata = {2{rs2[15:0]}}.
  - SW (010): be = 1111; wdata = rs2.
  - Any other func3 gives be = 0000. The bus transaction still occurs.
- Loads select lanes by a:
  - LB (000) and LH (001) sign-extend.
  - LBU (100) and LHU (101) zero-extend.
  - LW (010) passes the whole word.
  - Any other func3 returns 0.
- Completion:
  - Loads: MEM_out.wdata = aligned data; Wreg = latched Wreg.
  - Stores: MEM_out.Wreg = 0.

## Timing
- Reset (async, immediate): state = IDLE; MEM_out all fields 0; `misalign` = 0; latched request regs = 0.
- `dmem_req` and `stall` are combinational. They are 0 in reset because they follow the IDLE state and the reset upstream bundle.
- Reset during BUSY drops the request in the same cycle. The memory must tolerate an abandoned request.
- Latency:
  - Non-memory operation: 1 cycle to `MEM_out`.
  - Memory operation: 1 + N cycles, where N is the number of wait cycles before `dmem_ready`.
- If `dmem_ready` is asserted with `dmem_req` = 0, it is ignored.
- `EXE_out` must be held stable by upstream while `stall` = 1. In BUSY, the block uses only latched values.
- Back-to-back memory operations: the next operation may issue in the cycle after completion. There is no dead cycle.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A misaligned access is a halfword with a[0] = 1, or a word with a ≠ 00.
  - It issues no bus request: `dmem_req` = 0 and `stall` = 0.
  - Next edge: MEM_out bubble and `misalign` = 1 for one cycle.
- Macro undefined:
  - Low address bits that break alignment are ignored.
  - Halfwords use a[1] only; words use a = 00.
  - `misalign` is constant 0.

## Structure
- `core_types_pkg` gains:
  - `MEM_out_t`.
  - `mem_state_t` enum (IDLE, BUSY).
  - func3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
- One combinational sub-module, `load_align`: inputs rdata, a[1:0], func3; output 32-bit extended value.

## Test plan
- ALU passthrough: Wreg = 1, rd = 5, result = 0x1234 → next cycle MEM_out = {rd = 5, wdata = 0x1234, Wreg = 1}, with `dmem_req` = 0.
- SB at address 0x103, rs2 = 0xAB, ready tied 1 → same cycle be = 1000, wdata = 0xABABABAB, addr = 0x100; then MEM_out.Wreg = 0.
- LB at address 0x102 with rdata = 0x0080_0000 → wdata = 0xFFFFFF80. The same access as LBU → wdata = 0x00000080.
- LW with ready delayed 3 cycles → `stall` high for 3 cycles, addr and be stable, MEM_out bubbles, then wdata = rdata with Wreg = 1.
- Reset asserted in BUSY → `dmem_req` drops immediately, MEM_out = 0; after reset, a passthrough operation completes normally.
- With the macro defined: LH at address 0x101 → no request, `misalign` = 1 for one cycle, MEM_out.Wreg = 0.

Source files
------------

// File: rtl/core_types_pkg.sv
// rtl/core_types_pkg.sv - pipeline bundle types, memory-stage state and func3 encodings
package core_types_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [31:0] result;
    logic        Wmem;
    logic        Rmem;
    logic        Wreg;
    logic [2:0]  func3;
  } EXE_out_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        Wreg;
  } MEM_out_t;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mem_state_t;

  // Byte-lane enables for a store; unknown widths enable no lanes.
  function automatic logic [3:0] store_be(input logic [2:0] func3, input logic [1:0] a);
    case (func3)
      F3_B:    store_be = 4'b0001 << a;
      F3_H:    store_be = 4'b0011 << {a[1], 1'b0};
      F3_W:    store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  endfunction

  // Store data replicated across lanes so the strobes alone select placement.
  function automatic logic [31:0] store_wdata(input logic [2:0] func3, input logic [31:0] rs2);
    case (func3)
      F3_B:    store_wdata = {4{rs2[7:0]}};
      F3_H:    store_wdata = {2{rs2[15:0]}};
      default: store_wdata = rs2;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// rtl/mem_stage_load_align.sv - load lane selection and sign/zero extension
module load_align
  import core_types_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  a,
  input  logic [2:0]  func3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/halfword; halfwords use only a[1].
  always_comb begin
    byte_sel = rdata[{a, 3'b000} +: 8];
    half_sel = a[1] ? rdata[31:16] : rdata[15:0];
    case (func3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_W:    data = rdata;
      F3_BU:   data = {24'd0, byte_sel};
      F3_HU:   data = {16'd0, half_sel};
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage; MEM_MISALIGN_TRAP_EN enables misalignment trapping
module mem_stage
  import core_types_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              Clock,
  input  logic              nReset,
  input  EXE_out_t          EXE_out,
  output MEM_out_t          MEM_out,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata,
  output logic              misalign
);

  mem_state_t state_q, state_d;

  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [3:0]        lat_be;
  logic [31:0]       lat_wdata;
  logic [4:0]        lat_rd;
  logic [2:0]        lat_func3;
  logic              lat_wreg;
  logic [1:0]        lat_a;

  logic              mem_op;
  logic [1:0]        exe_a;
  logic [ADDR_W-1:0] exe_addr;
  logic [3:0]        exe_be;
  logic [31:0]       exe_wdata;
  logic              addr_bad;
  logic              trap_now;
  logic              done;
  logic [1:0]        cur_a;
  logic [2:0]        cur_func3;
  logic [4:0]        cur_rd;
  logic              cur_wreg;
  logic [31:0]       load_data;

  assign mem_op    = EXE_out.Wmem | EXE_out.Rmem;
  assign exe_a     = EXE_out.result[1:0];
  assign exe_addr  = {EXE_out.result[ADDR_W-1:2], 2'b00};
  assign exe_be    = EXE_out.Wmem ? store_be(EXE_out.func3, exe_a) : 4'b1111;
  assign exe_wdata = store_wdata(EXE_out.func3, EXE_out.rs2);

`ifdef MEM_MISALIGN_TRAP_EN
  // Halfwords need a[0]=0, words need a=00.
  always_comb begin
    case (EXE_out.func3)
      F3_H, F3_HU: addr_bad = exe_a[0];
      F3_W:        addr_bad = (exe_a != 2'b00);
      default:     addr_bad = 1'b0;
    endcase
  end
`else
  assign addr_bad = 1'b0;
`endif

  assign trap_now = (state_q == IDLE) && mem_op && addr_bad;

  // In BUSY the bus and completion path run only from the latched copy.
  assign dmem_we    = (state_q == BUSY) ? lat_we    : EXE_out.Wmem;
  assign dmem_addr  = (state_q == BUSY) ? lat_addr  : exe_addr;
  assign dmem_be    = (state_q == BUSY) ? lat_be    : exe_be;
  assign dmem_wdata = (state_q == BUSY) ? lat_wdata : exe_wdata;
  assign cur_a      = (state_q == BUSY) ? lat_a     : exe_a;
  assign cur_func3  = (state_q == BUSY) ? lat_func3 : EXE_out.func3;
  assign cur_rd     = (state_q == BUSY) ? lat_rd    : EXE_out.rd;
  assign cur_wreg   = (state_q == BUSY) ? lat_wreg  : EXE_out.Wreg;

  load_align u_load_align (
    .rdata (dmem_rdata),
    .a     (cur_a),
    .func3 (cur_func3),
    .data  (load_data)
  );

  // State register.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state plus request/stall: a request waits in BUSY until ready.
  always_comb begin
    state_d  = state_q;
    dmem_req = 1'b0;
    stall    = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        dmem_req = mem_op && !addr_bad;
        stall    = dmem_req && !dmem_ready;
        done     = dmem_req && dmem_ready;
        if (stall) state_d = BUSY;
      end
      BUSY: begin
        dmem_req = 1'b1;
        stall    = !dmem_ready;
        done     = dmem_ready;
        if (dmem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the request when it cannot finish in its issue cycle.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_be    <= 4'd0;
      lat_wdata <= 32'd0;
      lat_rd    <= 5'd0;
      lat_func3 <= 3'd0;
      lat_wreg  <= 1'b0;
      lat_a     <= 2'd0;
    end else if (state_q == IDLE && stall) begin
      lat_addr  <= exe_addr;
      lat_we    <= EXE_out.Wmem;
      lat_be    <= exe_be;
      lat_wdata <= exe_wdata;
      lat_rd    <= EXE_out.rd;
      lat_func3 <= EXE_out.func3;
      lat_wreg  <= EXE_out.Wreg;
      lat_a     <= exe_a;
    end
  end

  // MEM->WB bundle: bubbles while stalled or trapped, load data or store retire on completion.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      MEM_out <= '0;
    end else if (stall || trap_now) begin
      MEM_out <= '0;
    end else if (done) begin
      MEM_out.rd    <= cur_rd;
      MEM_out.wdata <= dmem_we ? 32'd0 : load_data;
      MEM_out.Wreg  <= dmem_we ? 1'b0 : cur_wreg;
    end else begin
      MEM_out.rd    <= EXE_out.rd;
      MEM_out.wdata <= EXE_out.result;
      MEM_out.Wreg  <= EXE_out.Wreg;
    end
  end

  // One-cycle flag for a trapped access.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) misalign <= 1'b0;
    else         misalign <= trap_now;
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;
  import core_types_pkg::*;

  logic        Clock = 1'b0;
  logic        nReset;
  EXE_out_t    EXE_out;
  MEM_out_t    MEM_out;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        misalign;

  int errors = 0;
  int checks = 0;

  mem_stage #(.ADDR_W(32)) dut (
    .Clock      (Clock),
    .nReset     (nReset),
    .EXE_out    (EXE_out),
    .MEM_out    (MEM_out),
    .stall      (stall),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .misalign   (misalign)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_op(input logic wm, input logic rm, input logic wr, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [31:0] res, input logic [31:0] rs2);
    EXE_out.Wmem   = wm;
    EXE_out.Rmem   = rm;
    EXE_out.Wreg   = wr;
    EXE_out.func3  = f3;
    EXE_out.rd     = rd;
    EXE_out.result = res;
    EXE_out.rs2    = rs2;
  endtask

  initial begin
    nReset = 1'b0;
    EXE_out = '0;
    dmem_ready = 1'b0;
    dmem_rdata = 32'd0;
    #1;
    check("rst_mem_out", MEM_out, 0);
    check("rst_req", dmem_req, 0);
    check("rst_stall", stall, 0);
    check("rst_misalign", misalign, 0);
    step();
    nReset = 1'b1;

    // ALU passthrough
    set_op(0, 0, 1, F3_B, 5'd5, 32'h1234, 32'h0);
    #1;
    check("pass_req", dmem_req, 0);
    check("pass_stall", stall, 0);
    step();
    check("pass_rd", MEM_out.rd, 5);
    check("pass_wdata", MEM_out.wdata, 32'h1234);
    check("pass_wreg", MEM_out.Wreg, 1);

    // SB at 0x103, ready tied high
    dmem_ready = 1'b1;
    set_op(1, 0, 1, F3_B, 5'd6, 32'h103, 32'hAB);
    #1;
    check("sb_req", dmem_req, 1);
    check("sb_we", dmem_we, 1);
    check("sb_be", dmem_be, 4'b1000);
    check("sb_wdata", dmem_wdata, 32'hABABABAB);
    check("sb_addr", dmem_addr, 32'h100);
    check("sb_stall", stall, 0);
    step();
    check("sb_wreg", MEM_out.Wreg, 0);

    // SH at 0x102
    set_op(1, 0, 0, F3_H, 5'd0, 32'h102, 32'h12345678);
    #1;
    check("sh_be", dmem_be, 4'b1100);
    check("sh_wdata", dmem_wdata, 32'h56785678);
    // store with unsupported func3 still issues, no lanes
    set_op(1, 0, 0, 3'b011, 5'd0, 32'h104, 32'h1);
    #1;
    check("sx_req", dmem_req, 1);
    check("sx_be", dmem_be, 4'b0000);
    step();

    // LB / LBU at 0x102
    dmem_rdata = 32'h0080_0000;
    set_op(0, 1, 1, F3_B, 5'd7, 32'h102, 32'h0);
    #1;
    check("lb_we", dmem_we, 0);
    step();
    check("lb_wdata", MEM_out.wdata, 32'hFFFFFF80);
    check("lb_rd", MEM_out.rd, 7);
    check("lb_wreg", MEM_out.Wreg, 1);
    set_op(0, 1, 1, F3_BU, 5'd7, 32'h102, 32'h0);
    step();
    check("lbu_wdata", MEM_out.wdata, 32'h00000080);

    // LH low half, LHU high half
    dmem_rdata = 32'h0000_8001;
    set_op(0, 1, 1, F3_H, 5'd8, 32'h100, 32'h0);
    step();
    check("lh_wdata", MEM_out.wdata, 32'hFFFF8001);
    dmem_rdata = 32'hBEEF_0000;
    set_op(0, 1, 1, F3_HU, 5'd8, 32'h102, 32'h0);
    step();
    check("lhu_wdata", MEM_out.wdata, 32'h0000BEEF);
    // store and load both set: store wins
    set_op(1, 1, 1, F3_W, 5'd8, 32'h108, 32'hCAFE0000);
    #1;
    check("both_we", dmem_we, 1);
    step();
    check("both_wreg", MEM_out.Wreg, 0);

    // LW with 3 wait cycles
    dmem_ready = 1'b0;
    dmem_rdata = 32'hDEADBEEF;
    set_op(0, 1, 1, F3_W, 5'd9, 32'h200, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("lw_stall%0d", i), stall, 1);
      check($sformatf("lw_req%0d", i), dmem_req, 1);
      check($sformatf("lw_addr%0d", i), dmem_addr, 32'h200);
      check($sformatf("lw_be%0d", i), dmem_be, 4'b1111);
      step();
      check($sformatf("lw_bubble%0d", i), MEM_out, 0);
    end
    dmem_ready = 1'b1;
    #1;
    check("lw_stall_done", stall, 0);
    step();
    EXE_out = '0;
    check("lw_wdata", MEM_out.wdata, 32'hDEADBEEF);
    check("lw_wreg", MEM_out.Wreg, 1);
    check("lw_rd", MEM_out.rd, 9);

    // Reset while BUSY
    dmem_ready = 1'b0;
    set_op(0, 1, 1, F3_W, 5'd10, 32'h300, 32'h0);
    step();
    check("rb_req_busy", dmem_req, 1);
    nReset = 1'b0;
    EXE_out = '0;
    #1;
    check("rb_req_drop", dmem_req, 0);
    check("rb_mem_out", MEM_out, 0);
    step();
    nReset = 1'b1;
    set_op(0, 0, 1, F3_B, 5'd3, 32'h55, 32'h0);
    #1;
    check("rb_pass_req", dmem_req, 0);
    step();
    check("rb_pass_rd", MEM_out.rd, 3);
    check("rb_pass_wdata", MEM_out.wdata, 32'h55);
    check("rb_pass_wreg", MEM_out.Wreg, 1);

    // LH at 0x101
    dmem_ready = 1'b1;
    dmem_rdata = 32'h1234_5678;
    set_op(0, 1, 1, F3_H, 5'd4, 32'h101, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
    #1;
    check("mis_req", dmem_req, 0);
    check("mis_stall", stall, 0);
    step();
    check("mis_flag", misalign, 1);
    check("mis_wreg", MEM_out.Wreg, 0);
    EXE_out = '0;
    step();
    check("mis_flag_clr", misalign, 0);
`else
    #1;
    check("lh101_req", dmem_req, 1);
    step();
    check("lh101_wdata", MEM_out.wdata, 32'h00005678);
    check("lh101_misalign", misalign, 0);
    EXE_out = '0;
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
